jkff_bist_ctrl: RTL

Built-in self-test sequencer for the JK flip-flop next-state logic block (inputs j, k, q_in; output y).
- Drives all eight {j,k,q} input patterns into the DUT for PASSES sweeps, waits a programmable settle time per pattern, samples y and compares it against the golden equation y = (j & ~q) | (~k & q).
- Reports pass/fail, an error count and the first failing vector; optionally compacts responses into a MISR signature.
- Sits between the ATPG test harness (start/abort/status) and the combinational DUT.

---
 rtl/jkff_bist_pkg.sv | 29 ++
 rtl/jkff_bist_ctrl_if.sv | 33 +++
 rtl/jkff_misr.sv | 44 ++++
 rtl/jkff_bist_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jkff_bist_pkg.sv
// -----------------------------------------------------------------------------
// jkff_bist_pkg
// Shared definitions for the JK flip-flop next-state BIST sequencer:
//   - state_e    : sequencer states (IDLE, DRIVE, CAPTURE, DONE)
//   - PAT_W      : width of a {j,k,q} stimulus pattern
//   - MISR_POLY  : feedback polynomial of the response compactor
//   - golden_y() : reference next-state equation y = (j & ~q) | (~k & q)
// No ports (package).
// -----------------------------------------------------------------------------
package jkff_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int         PAT_W     = 3;
  localparam logic [7:0] MISR_POLY = 8'h1D;

  // Expected JK next state for pattern {j,k,q}.
  function automatic logic golden_y(input logic [PAT_W-1:0] pat);
    logic j, k, q;
    {j, k, q} = pat;
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jkff_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// jkff_bist_ctrl_if
// Harness-side control/status bundle of the BIST sequencer.
//   start, abort                    : harness -> sequencer
//   busy, done, pass                : run status
//   err_cnt[7:0]                    : saturating mismatch count
//   first_fail[2:0], first_fail_vld : {j,k,q} of the first mismatch
//   signature[SIG_W-1:0]            : MISR contents (0 when MISR not built)
// Modports: master = ATPG harness, slave = sequencer.
// -----------------------------------------------------------------------------
interface jkff_bist_ctrl_if #(
  parameter int SIG_W = 8
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_cnt;
  logic [2:0]       first_fail;
  logic             first_fail_vld;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, abort,
    input  busy, done, pass, err_cnt, first_fail, first_fail_vld, signature
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, err_cnt, first_fail, first_fail_vld, signature
  );
endinterface

// File: rtl/jkff_misr.sv
// -----------------------------------------------------------------------------
// jkff_misr
// Serial-input multiple-input signature register compacting DUT responses.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : seed the register to 0 (wins over en)
//   en         : shift in din this cycle
//   din        : response bit
//   sig[W-1:0] : current signature
// Update: sig <= (sig << 1) ^ (sig[W-1] ? POLY : 0) ^ din.
// Only instantiated when JKFF_BIST_MISR_EN is defined.
// -----------------------------------------------------------------------------
module jkff_misr
  import jkff_bist_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = MISR_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ {{(W-1){1'b0}}, din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/jkff_bist_ctrl.sv
// -----------------------------------------------------------------------------
// jkff_bist_ctrl
// BIST sequencer for the combinational JK flip-flop next-state block.
// Sweeps all eight {j,k,q} patterns PASSES times, holds each pattern for
// SETTLE_CYCLES cycles, then samples dut_y for one CAPTURE cycle and compares
// it with the golden equation. Reports pass/fail, error count, first failing
// vector and (optionally) a MISR signature.
// Parameters: SETTLE_CYCLES (1..15), PASSES (1..16), SIG_W (8).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : start/abort in, status out (see jkff_bist_ctrl_if)
//   dut_j, dut_k, dut_q : registered stimulus to the DUT
//   dut_y               : DUT response
// Build option: define JKFF_BIST_MISR_EN to build the response MISR;
// otherwise signature is tied to 0.
// -----------------------------------------------------------------------------
module jkff_bist_ctrl
  import jkff_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int SIG_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  jkff_bist_ctrl_if.slave    bus,
  output logic               dut_j,
  output logic               dut_k,
  output logic               dut_q,
  input  logic               dut_y
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] dut_pat_q, dut_pat_d;
  logic [3:0]       pass_idx_q, pass_idx_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [PAT_W-1:0] first_fail_q, first_fail_d;
  logic             first_fail_vld_q, first_fail_vld_d;

  // A run starts only from IDLE/DONE, and abort always beats start.
  logic start_go;
  logic capture_en;
  logic mismatch;

  assign start_go   = bus.start && !bus.abort && (state_q == IDLE || state_q == DONE);
  assign capture_en = (state_q == CAPTURE) && !bus.abort;
  assign mismatch   = dut_y ^ golden_y(pat_q);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d          = state_q;
    pat_d            = pat_q;
    dut_pat_d        = dut_pat_q;
    pass_idx_d       = pass_idx_q;
    settle_cnt_d     = settle_cnt_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_cnt_d        = err_cnt_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_go) begin
          err_cnt_d        = '0;
          first_fail_d     = '0;
          first_fail_vld_d = 1'b0;
          pass_d           = 1'b0;
          pat_d            = '0;
          pass_idx_d       = '0;
          settle_cnt_d     = SETTLE_LOAD;
          dut_pat_d        = '0;
          busy_d           = 1'b1;
          state_d          = DRIVE;
        end else if (state_q == DONE) begin
          dut_pat_d = '0;
          state_d   = IDLE;
        end
      end

      DRIVE: begin
        if (settle_cnt_q == 4'd0) state_d = CAPTURE;
        else                      settle_cnt_d = settle_cnt_q - 4'd1;
      end

      CAPTURE: begin
        if (capture_en) begin
          if (mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!first_fail_vld_q) begin
              first_fail_d     = pat_q;
              first_fail_vld_d = 1'b1;
            end
          end
          if (pat_q == 3'd7 && pass_idx_q == PASS_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // err_cnt_d already includes this final capture.
            pass_d  = (err_cnt_d == 8'd0);
            state_d = DONE;
          end else begin
            pat_d        = pat_q + 3'd1;
            dut_pat_d    = pat_q + 3'd1;
            if (pat_q == 3'd7) pass_idx_d = pass_idx_q + 4'd1;
            settle_cnt_d = SETTLE_LOAD;
            state_d      = DRIVE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort: back to IDLE, status left with its partial values.
    if (bus.abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      dut_pat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pat_q            <= '0;
      dut_pat_q        <= '0;
      pass_idx_q       <= '0;
      settle_cnt_q     <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop captures the pre-edge _d values.
      state_q          <= state_d;
      pat_q            <= pat_d;
      dut_pat_q        <= dut_pat_d;
      pass_idx_q       <= pass_idx_d;
      settle_cnt_q     <= settle_cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_cnt_q        <= err_cnt_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
    end
  end

  assign {dut_j, dut_k, dut_q} = dut_pat_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.pass              = pass_q;
  assign bus.err_cnt           = err_cnt_q;
  assign bus.first_fail        = first_fail_q;
  assign bus.first_fail_vld    = first_fail_vld_q;

`ifdef JKFF_BIST_MISR_EN
  jkff_misr #(
    .W    (SIG_W),
    .POLY (SIG_W'(MISR_POLY))
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .en    (capture_en),
    .din   (dut_y),
    .sig   (bus.signature)
  );
`else
  assign bus.signature = {SIG_W{1'b0}};
`endif

endmodule
